// File: rtl/ip_codma_bus_arbiter_if.sv
// Bus-side signal bundle between the co-DMA arbiter and the system bus.
// The arbiter drives the request strobes, address, size and write data.
// The bus answers with a grant and a per-beat transfer strobe.
interface ip_codma_bus_arbiter_if;
  logic        bus_read_o;
  logic        bus_write_o;
  logic        bus_write_valid_o;
  logic [31:0] bus_addr_o;
  logic [7:0]  bus_size_o;
  logic [63:0] bus_write_data_o;
  logic        bus_grant_i;
  logic        bus_beat_i;

  modport master (
    output bus_read_o,
    output bus_write_o,
    output bus_write_valid_o,
    output bus_addr_o,
    output bus_size_o,
    output bus_write_data_o,
    input  bus_grant_i,
    input  bus_beat_i
  );

  modport slave (
    input  bus_read_o,
    input  bus_write_o,
    input  bus_write_valid_o,
    input  bus_addr_o,
    input  bus_size_o,
    input  bus_write_data_o,
    output bus_grant_i,
    output bus_beat_i
  );
endinterface

// File: rtl/ip_codma_bus_arbiter.sv
// Co-DMA bus arbiter.
// The read and write machines share one system bus through this block.
// Arbitration is round-robin, and read wins the first tie after reset.
// The owner's address and size are latched when a request is accepted.
// A transfer is then asked for, owned, counted beat by beat and completed.
// A grant timeout, a stop request and a main-machine error halt all abort it.
module ip_codma_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  IDLE_SIZE      = 8'd9
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          stop_i,
  input  logic                          error_i,
  input  logic                          rd_req_i,
  input  logic [31:0]                   rd_addr_i,
  input  logic [7:0]                    rd_size_i,
  input  logic                          wr_req_i,
  input  logic [31:0]                   wr_addr_i,
  input  logic [7:0]                    wr_size_i,
  input  logic [63:0]                   wr_data_i,
  output logic                          rd_gnt_o,
  output logic                          wr_gnt_o,
  output logic                          rd_done_o,
  output logic                          wr_done_o,
  output logic [7:0]                    beat_cnt_o,
  output logic                          timeout_o,
  ip_codma_bus_arbiter_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASK_RD  = 3'd1,
    ASK_WR  = 3'd2,
    XFER_RD = 3'd3,
    XFER_WR = 3'd4,
    HALT    = 3'd5
  } state_t;

  // Last ASK cycle index before the grant wait is abandoned.
  localparam logic [7:0] ASK_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last_wr;
  logic [31:0] addr_q;
  logic [7:0]  size_q;
  logic [7:0]  beat_cnt;
  logic [7:0]  ask_cnt;
  logic        timeout_q;
  logic [7:0]  beat_next;
  logic        rd_fin;
  logic        wr_fin;
  logic        owned;

  // The beat count as it will stand once this cycle's beat is included.
  assign beat_next = beat_cnt + {7'd0, bus.bus_beat_i};

  // A transfer finishes on its last beat.
  // A zero-length transfer finishes on the grant cycle instead.
  assign rd_fin = ((state == XFER_RD) && (beat_next == size_q)) ||
                  ((state == ASK_RD) && bus.bus_grant_i && (size_q == 8'd0));
  assign wr_fin = ((state == XFER_WR) && (beat_next == size_q)) ||
                  ((state == ASK_WR) && bus.bus_grant_i && (size_q == 8'd0));

  // An abort in the finishing cycle wins, so no done pulse is reported.
  assign rd_done_o = rd_fin && !error_i && !stop_i;
  assign wr_done_o = wr_fin && !error_i && !stop_i;

  // Arbitration, transfer sequencing and abort handling.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      last_wr   <= 1'b1;
      addr_q    <= 32'd0;
      size_q    <= 8'd0;
      beat_cnt  <= 8'd0;
      ask_cnt   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (error_i) begin
        state    <= HALT;
        beat_cnt <= 8'd0;
      end else if (stop_i && (state != HALT)) begin
        state    <= IDLE;
        beat_cnt <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (rd_req_i && (!wr_req_i || last_wr)) begin
              state    <= ASK_RD;
              addr_q   <= rd_addr_i;
              size_q   <= rd_size_i;
              beat_cnt <= 8'd0;
              ask_cnt  <= 8'd0;
            end else if (wr_req_i) begin
              state    <= ASK_WR;
              addr_q   <= wr_addr_i;
              size_q   <= wr_size_i;
              beat_cnt <= 8'd0;
              ask_cnt  <= 8'd0;
            end
          end
          ASK_RD, ASK_WR: begin
            if (bus.bus_grant_i) begin
              if (size_q == 8'd0) begin
                state   <= IDLE;
                last_wr <= (state == ASK_WR);
              end else begin
                state <= (state == ASK_RD) ? XFER_RD : XFER_WR;
              end
            end else if (ask_cnt == ASK_LIMIT) begin
              state     <= IDLE;
              timeout_q <= 1'b1;
            end else begin
              ask_cnt <= ask_cnt + 8'd1;
            end
          end
          XFER_RD, XFER_WR: begin
            beat_cnt <= beat_next;
            if (beat_next == size_q) begin
              state   <= IDLE;
              last_wr <= (state == XFER_WR);
            end
          end
          HALT: begin
            if (stop_i) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign owned      = (state == ASK_RD) || (state == ASK_WR) ||
                      (state == XFER_RD) || (state == XFER_WR);
  assign rd_gnt_o   = (state == XFER_RD);
  assign wr_gnt_o   = (state == XFER_WR);
  assign beat_cnt_o = beat_cnt;
  assign timeout_o  = timeout_q;

  assign bus.bus_read_o        = (state == ASK_RD);
  assign bus.bus_write_o       = (state == ASK_WR);
  assign bus.bus_write_valid_o = (state == XFER_WR);
  assign bus.bus_addr_o        = owned ? addr_q : 32'd0;
  assign bus.bus_size_o        = owned ? size_q : IDLE_SIZE;
  assign bus.bus_write_data_o  = (state == XFER_WR) ? wr_data_i : 64'd0;

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// Directed bench for the co-DMA bus arbiter.
// Each row of the vector table is one clock cycle.
// A row drives the inputs at the falling edge and checks the outputs shortly after.
module tb_ip_codma_bus_arbiter;

  localparam logic [31:0] RA  = 32'h1000_0040;
  localparam logic [31:0] WA  = 32'h2000_0080;
  localparam logic [7:0]  IS  = 8'd9;
  localparam logic [63:0] Z64 = 64'd0;
  localparam logic [63:0] D1  = 64'hA5A5_0000_1111_0001;
  localparam logic [63:0] D2  = 64'h5A5A_FFFF_2222_0002;
  localparam logic [63:0] D3  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D4  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D5  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D6  = 64'h0F0F_0F0F_F0F0_F0F0;

  typedef struct packed {
    logic        stop;
    logic        err;
    logic        rd_req;
    logic        wr_req;
    logic        grant;
    logic        beat;
    logic [7:0]  rd_size;
    logic [7:0]  wr_size;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
  } ins_t;

  typedef struct packed {
    logic        rd_gnt;
    logic        wr_gnt;
    logic        rd_done;
    logic        wr_done;
    logic        timeout;
    logic        bus_read;
    logic        bus_write;
    logic        bus_wvalid;
    logic [7:0]  beat_cnt;
    logic [7:0]  bus_size;
    logic [31:0] bus_addr;
    logic [63:0] bus_wdata;
  } outs_t;

  typedef struct packed {
    ins_t  stim;
    outs_t want;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        stop_i, error_i;
  logic        rd_req_i, wr_req_i;
  logic [31:0] rd_addr_i, wr_addr_i;
  logic [7:0]  rd_size_i, wr_size_i;
  logic [63:0] wr_data_i;
  logic        rd_gnt_o, wr_gnt_o, rd_done_o, wr_done_o, timeout_o;
  logic [7:0]  beat_cnt_o;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  ip_codma_bus_arbiter_if bus_if ();

  ip_codma_bus_arbiter #(.TIMEOUT_CYCLES(8), .IDLE_SIZE(8'd9)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .stop_i     (stop_i),
    .error_i    (error_i),
    .rd_req_i   (rd_req_i),
    .rd_addr_i  (rd_addr_i),
    .rd_size_i  (rd_size_i),
    .wr_req_i   (wr_req_i),
    .wr_addr_i  (wr_addr_i),
    .wr_size_i  (wr_size_i),
    .wr_data_i  (wr_data_i),
    .rd_gnt_o   (rd_gnt_o),
    .wr_gnt_o   (wr_gnt_o),
    .rd_done_o  (rd_done_o),
    .wr_done_o  (wr_done_o),
    .beat_cnt_o (beat_cnt_o),
    .timeout_o  (timeout_o),
    .bus        (bus_if)
  );

  always #5 clk_i = ~clk_i;

  function automatic ins_t mkIn(input int stop, input int err, input int rr, input int rs,
                                input int wr, input int ws, input logic [63:0] wd,
                                input int g, input int b);
    ins_t s;
    s.stop    = 1'(stop);
    s.err     = 1'(err);
    s.rd_req  = 1'(rr);
    s.wr_req  = 1'(wr);
    s.grant   = 1'(g);
    s.beat    = 1'(b);
    s.rd_size = 8'(rs);
    s.wr_size = 8'(ws);
    s.rd_addr = RA;
    s.wr_addr = WA;
    s.wr_data = wd;
    return s;
  endfunction

  function automatic outs_t mkOut(input int rg, input int wg, input int rdn, input int wdn,
                                  input int to, input int br, input int bw, input int bv,
                                  input int cnt, input int sz, input logic [31:0] ad,
                                  input logic [63:0] wd);
    outs_t o;
    o.rd_gnt     = 1'(rg);
    o.wr_gnt     = 1'(wg);
    o.rd_done    = 1'(rdn);
    o.wr_done    = 1'(wdn);
    o.timeout    = 1'(to);
    o.bus_read   = 1'(br);
    o.bus_write  = 1'(bw);
    o.bus_wvalid = 1'(bv);
    o.beat_cnt   = 8'(cnt);
    o.bus_size   = 8'(sz);
    o.bus_addr   = ad;
    o.bus_wdata  = wd;
    return o;
  endfunction

  function automatic outs_t oIdle(input int cnt);
    return mkOut(0, 0, 0, 0, 0, 0, 0, 0, cnt, int'(IS), 32'd0, Z64);
  endfunction

  function automatic outs_t oAskR(input int sz, input int dn);
    return mkOut(0, 0, dn, 0, 0, 1, 0, 0, 0, sz, RA, Z64);
  endfunction

  function automatic outs_t oAskW(input int sz, input int dn);
    return mkOut(0, 0, 0, dn, 0, 0, 1, 0, 0, sz, WA, Z64);
  endfunction

  function automatic outs_t oXR(input int cnt, input int sz, input int dn);
    return mkOut(1, 0, dn, 0, 0, 0, 0, 0, cnt, sz, RA, Z64);
  endfunction

  function automatic outs_t oXW(input int cnt, input int sz, input int dn, input logic [63:0] d);
    return mkOut(0, 1, 0, dn, 0, 0, 0, 1, cnt, sz, WA, d);
  endfunction

  task automatic addRow(input ins_t s, input outs_t w);
    vec_t v;
    v.stim = s;
    v.want = w;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input ins_t s);
    @(negedge clk_i);
    stop_i             = s.stop;
    error_i            = s.err;
    rd_req_i           = s.rd_req;
    wr_req_i           = s.wr_req;
    rd_size_i          = s.rd_size;
    wr_size_i          = s.wr_size;
    rd_addr_i          = s.rd_addr;
    wr_addr_i          = s.wr_addr;
    wr_data_i          = s.wr_data;
    bus_if.bus_grant_i = s.grant;
    bus_if.bus_beat_i  = s.beat;
  endtask

  task automatic checkOutput(input outs_t w, input string name);
    outs_t a;
    int strobes;
    #1;
    a.rd_gnt     = rd_gnt_o;
    a.wr_gnt     = wr_gnt_o;
    a.rd_done    = rd_done_o;
    a.wr_done    = wr_done_o;
    a.timeout    = timeout_o;
    a.bus_read   = bus_if.bus_read_o;
    a.bus_write  = bus_if.bus_write_o;
    a.bus_wvalid = bus_if.bus_write_valid_o;
    a.beat_cnt   = beat_cnt_o;
    a.bus_size   = bus_if.bus_size_o;
    a.bus_addr   = bus_if.bus_addr_o;
    a.bus_wdata  = bus_if.bus_write_data_o;
    total++;
    if (a !== w) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, a, w);
    end
    strobes = int'(a.bus_read) + int'(a.bus_write) + int'(a.bus_wvalid);
    total++;
    if (strobes > 1 || (a.rd_gnt && a.wr_gnt)) begin
      bad++;
      $display("[TB] FAIL %s exclusive strobes=%0d gnt=%b%b want strobes<=1 and single gnt",
               name, strobes, a.rd_gnt, a.wr_gnt);
    end
  endtask

  task automatic stepRow(input ins_t s, input outs_t w, input string name);
    applyStimulus(s);
    checkOutput(w, name);
  endtask

  initial begin
    ins_t  s;

    // Arbitration from reset: read, write, read, write
    addRow(mkIn(0,0,1,1,1,2,Z64,1,0), oIdle(0));
    addRow(mkIn(0,0,1,1,1,2,Z64,1,0), oAskR(1,0));
    addRow(mkIn(0,0,1,1,1,2,Z64,0,1), oXR(0,1,1));
    addRow(mkIn(0,0,1,1,1,2,Z64,0,0), oIdle(1));
    addRow(mkIn(0,0,1,1,1,2,Z64,1,0), oAskW(2,0));
    addRow(mkIn(0,0,1,1,1,2,D1,0,1),  oXW(0,2,0,D1));
    addRow(mkIn(0,0,1,1,1,2,D2,0,1),  oXW(1,2,1,D2));
    addRow(mkIn(0,0,1,1,1,2,Z64,0,0), oIdle(2));
    addRow(mkIn(0,0,1,1,1,2,Z64,1,0), oAskR(1,0));
    addRow(mkIn(0,0,1,1,1,2,Z64,0,1), oXR(0,1,1));
    addRow(mkIn(0,0,0,1,1,2,Z64,0,0), oIdle(1));
    addRow(mkIn(0,0,0,1,1,2,Z64,1,0), oAskW(2,0));
    addRow(mkIn(0,0,0,1,1,2,D3,0,0),  oXW(0,2,0,D3));
    addRow(mkIn(0,0,0,1,1,2,D3,0,1),  oXW(0,2,0,D3));
    addRow(mkIn(0,0,0,1,1,2,D4,0,1),  oXW(1,2,1,D4));
    addRow(mkIn(0,0,0,1,0,2,Z64,0,0), oIdle(2));
    // Read of 4 beats, grant on the second ASK cycle
    addRow(mkIn(0,0,1,4,0,0,Z64,0,0), oIdle(2));
    addRow(mkIn(0,0,1,4,0,0,Z64,0,0), oAskR(4,0));
    addRow(mkIn(0,0,1,4,0,0,Z64,1,0), oAskR(4,0));
    addRow(mkIn(0,0,1,4,0,0,Z64,0,1), oXR(0,4,0));
    addRow(mkIn(0,0,1,4,0,0,Z64,0,1), oXR(1,4,0));
    addRow(mkIn(0,0,1,4,0,0,Z64,0,1), oXR(2,4,0));
    addRow(mkIn(0,0,1,4,0,0,Z64,0,1), oXR(3,4,1));
    addRow(mkIn(0,0,0,4,0,0,Z64,0,0), oIdle(4));
    // Write never granted: eight ASK cycles, then a timeout pulse
    addRow(mkIn(0,0,0,0,1,3,Z64,0,0), oIdle(4));
    for (int k = 0; k < 8; k++) addRow(mkIn(0,0,0,0,1,3,Z64,0,0), oAskW(3,0));
    addRow(mkIn(0,0,0,0,0,3,Z64,0,0), mkOut(0,0,0,0,1,0,0,0,0,int'(IS),32'd0,Z64));
    addRow(mkIn(0,0,0,0,0,3,Z64,0,0), oIdle(0));
    // Zero-length read completes on the grant cycle
    addRow(mkIn(0,0,1,0,0,0,Z64,0,0), oIdle(0));
    addRow(mkIn(0,0,1,0,0,0,Z64,1,0), oAskR(0,1));
    addRow(mkIn(0,0,0,0,0,0,Z64,0,0), oIdle(0));

    stop_i = 1'b0; error_i = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0;
    rd_addr_i = 32'd0; wr_addr_i = 32'd0; rd_size_i = 8'd0; wr_size_i = 8'd0;
    wr_data_i = Z64; bus_if.bus_grant_i = 1'b0; bus_if.bus_beat_i = 1'b0;
    reset_n_i = 1'b0;
    checkOutput(oIdle(0), "reset state");
    @(negedge clk_i);
    reset_n_i = 1'b1;

    foreach (vecs[i]) stepRow(vecs[i].stim, vecs[i].want, $sformatf("row%0d", i));

    // Stop at beat 2 of 6; requester inputs change after the latch
    stepRow(mkIn(0,0,1,6,0,0,Z64,0,0), oIdle(0), "stop s0");
    stepRow(mkIn(0,0,1,6,0,0,Z64,1,0), oAskR(6,0), "stop s1");
    s = mkIn(0,0,1,6,0,0,Z64,0,1); s.rd_addr = 32'hDEAD_BEEC; s.rd_size = 8'd7;
    stepRow(s, oXR(0,6,0), "latch s2");
    stepRow(s, oXR(1,6,0), "latch s3");
    s.stop = 1'b1;
    stepRow(s, oXR(2,6,0), "stop s4");
    stepRow(mkIn(0,0,0,0,0,0,Z64,0,0), oIdle(0), "stop s5");

    // Error during a write, then HALT exit rules
    stepRow(mkIn(0,0,0,0,1,4,Z64,0,0), oIdle(0), "err e0");
    stepRow(mkIn(0,0,0,0,1,4,Z64,1,0), oAskW(4,0), "err e1");
    stepRow(mkIn(0,0,0,0,1,4,D5,0,1), oXW(0,4,0,D5), "err e2");
    stepRow(mkIn(0,1,0,0,1,4,D6,0,1), oXW(1,4,0,D6), "err e3");
    stepRow(mkIn(1,1,0,0,1,4,Z64,0,0), oIdle(0), "halt stop+err");
    stepRow(mkIn(0,0,0,0,1,4,Z64,0,0), oIdle(0), "halt no stop");
    stepRow(mkIn(1,0,0,0,1,4,Z64,0,0), oIdle(0), "halt exit");
    stepRow(mkIn(0,0,0,0,1,4,Z64,0,0), oIdle(0), "after halt idle");
    stepRow(mkIn(1,0,0,0,1,4,Z64,0,0), oAskW(4,0), "ask after halt");
    stepRow(mkIn(0,0,0,0,0,4,Z64,0,0), oIdle(0), "stop in ask");

    // Asynchronous reset in the middle of a write
    stepRow(mkIn(0,0,0,0,1,3,Z64,0,0), oIdle(0), "rst m0");
    stepRow(mkIn(0,0,0,0,1,3,Z64,1,0), oAskW(3,0), "rst m1");
    stepRow(mkIn(0,0,0,0,1,3,D1,0,1), oXW(0,3,0,D1), "rst m2");
    #1 reset_n_i = 1'b0;
    checkOutput(oIdle(0), "async reset");
    applyStimulus(mkIn(0,0,1,2,1,3,Z64,0,0));
    reset_n_i = 1'b1;
    checkOutput(oIdle(0), "post reset idle");
    stepRow(mkIn(1,0,1,2,1,3,Z64,0,0), oAskR(2,0), "read wins after reset");
    stepRow(mkIn(0,0,0,0,0,0,Z64,0,0), oIdle(0), "final idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
